// File: rtl/bus_transfer_ctrl_if.sv
// Handshake and bus signal bundle for bus_transfer_ctrl.
// The master side drives requests and the monitored bus; the slave side is the controller.
interface bus_transfer_ctrl_if #(
  parameter int WIDTH = 8,
  parameter int NREGS = 8
);
  localparam int SW = $clog2(NREGS);

  logic             req;
  logic [SW-1:0]    src_sel;
  logic [SW-1:0]    dst_sel;
  logic             ready;
  logic [NREGS-1:0] write_enable;
  logic [NREGS-1:0] read_enable;
  logic [WIDTH-1:0] bus_in;
  logic [WIDTH-1:0] xfer_data;
  logic             done;
  logic             err;

  modport master (
    output req, src_sel, dst_sel, bus_in,
    input  ready, write_enable, read_enable, xfer_data, done, err
  );

  modport slave (
    input  req, src_sel, dst_sel, bus_in,
    output ready, write_enable, read_enable, xfer_data, done, err
  );
endinterface

// File: rtl/bus_transfer_ctrl.sv
// Sequences one register-to-register move over a shared bus: drive, latch, hold, done.
// Optional macro BUS_XFER_CAPTURE_EN adds a register capturing the transferred bus value.
module bus_transfer_ctrl #(
  parameter int WIDTH = 8,
  parameter int NREGS = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  bus_transfer_ctrl_if.slave bus
);
  localparam int SW = $clog2(NREGS);
  localparam logic [SW:0] NREGS_W = (SW + 1)'(NREGS);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    DRIVE = 3'd1,
    LATCH = 3'd2,
    HOLD  = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [SW-1:0]    r_src;
  logic [SW-1:0]    r_dst;
  logic             r_ready;
  logic             r_err;
  logic             w_legal;
  logic             w_accept;
  logic             w_reject;
  logic [NREGS-1:0] w_we;
  logic [NREGS-1:0] w_re;

  function automatic logic [NREGS-1:0] f_onehot(input logic [SW-1:0] idx);
    logic [NREGS-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  assign w_legal = (bus.src_sel != bus.dst_sel) &&
                   ({1'b0, bus.src_sel} < NREGS_W) &&
                   ({1'b0, bus.dst_sel} < NREGS_W);

  // Next-state logic; req and selects only matter while idle.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_reject    = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.req) begin
          if (w_legal) begin
            w_accept    = 1'b1;
            w_state_nxt = DRIVE;
          end else begin
            w_reject    = 1'b1;
            w_state_nxt = IDLE;
          end
        end else begin
          w_state_nxt = IDLE;
        end
      end
      DRIVE:   w_state_nxt = LATCH;
      LATCH:   w_state_nxt = HOLD;
      HOLD:    w_state_nxt = DONE;
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // State, captured selects, and registered ready/err flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_src   <= '0;
      r_dst   <= '0;
      r_ready <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_ready <= (w_state_nxt == IDLE);
      r_err   <= w_reject;
      if (w_accept) begin
        r_src <= bus.src_sel;
        r_dst <= bus.dst_sel;
      end else begin
        r_src <= r_src;
        r_dst <= r_dst;
      end
    end
  end

  // Enables decode from registered state only; src != dst keeps read and write disjoint.
  always_comb begin
    w_we = '0;
    w_re = '0;
    case (r_state)
      DRIVE, HOLD: w_we = f_onehot(r_src);
      LATCH: begin
        w_we = f_onehot(r_src);
        w_re = f_onehot(r_dst);
      end
      default: begin
        w_we = '0;
        w_re = '0;
      end
    endcase
  end

  assign bus.write_enable = w_we;
  assign bus.read_enable  = w_re;
  assign bus.ready        = r_ready;
  assign bus.err          = r_err;
  assign bus.done         = (r_state == DONE);

`ifdef BUS_XFER_CAPTURE_EN
  logic [WIDTH-1:0] r_xfer;

  // Capture the bus on the edge that closes the latch window.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_xfer <= '0;
    end else if (r_state == LATCH) begin
      r_xfer <= bus.bus_in;
    end else begin
      r_xfer <= r_xfer;
    end
  end

  assign bus.xfer_data = r_xfer;
`else
  logic w_unused_bus;
  assign w_unused_bus  = ^bus.bus_in;
  assign bus.xfer_data = '0;
`endif
endmodule
